// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-step 1-bit shifter. An accepted start captures an operand, an opcode
// and a step count, then applies one shift step per clock while in RUN. A
// single-cycle done pulse marks the result, which is held on dout until the
// next accepted start.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   rst    - asynchronous active-high reset
//   start  - begin an operation (only looked at in IDLE)
//   din    - operand loaded into dout on an accepted start
//   op     - shift opcode captured on an accepted start
//   count  - number of 1-bit steps (0..WIDTH-1) captured on an accepted start
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse, high only in DONE
//   dout   - working / result register
//   err    - captured opcode unsupported; held until the next accepted start
module shift_sequencer #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      op_q;
    logic [CW-1:0]   remaining;

    function automatic logic op_supported(input logic [2:0] o);
        case (o)
            3'b001, 3'b100, 3'b101, 3'b110: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    endfunction

    // One shift step; unsupported opcodes leave the value untouched.
    function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] o,
                                                    input logic [WIDTH-1:0] v);
        case (o)
            3'b001:  shift_step = {v[WIDTH-2:0], 1'b0};
            3'b100:  shift_step = {1'b0, v[WIDTH-1:1]};
            3'b101:  shift_step = {v[WIDTH-2:0], 1'b1};
            3'b110:  shift_step = {1'b1, v[WIDTH-1:1]};
            default: shift_step = v;
        endcase
    endfunction

    // A zero count skips RUN; the last RUN step is the one that sees remaining==1.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (remaining == CW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: capture on accept, step in RUN, hold everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout      <= '0;
            op_q      <= 3'b000;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dout      <= din;
                        op_q      <= op;
                        remaining <= count;
                        err       <= ~op_supported(op);
                    end
                end
                RUN: begin
                    dout <= shift_step(op_q, dout);
                    // Guarded so the counter can never wrap below zero.
                    if (remaining != '0) begin
                        remaining <= remaining - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
